// File: rtl/axi_rd_fifo_slave.sv
// AXI4-Lite read-only slave that drains a datapath word FIFO and exposes status/ID registers.
// Optional AXI_RD_SLVERR_EN: unmapped reads and DATA reads on an empty FIFO return SLVERR.
module axi_rd_fifo_slave #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          IRQ_THRESH = 8,
  parameter logic [31:0] ID_VALUE   = 32'hC0_11_00_01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  localparam logic [WA_W-1:0] A_DATA   = WA_W'(0);
  localparam logic [WA_W-1:0] A_STATUS = WA_W'(1);
  localparam logic [WA_W-1:0] A_ID     = WA_W'(2);
  localparam logic [WA_W-1:0] A_THRESH = WA_W'(3);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rd_rsp_t;

  state_t state, state_nxt;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level, level_nxt;
  logic             ovf;

  logic [WA_W-1:0] word_addr;
  logic            ar_hs, empty, full, pop, push_ok, ovf_set, ovf_clr;
  rd_rsp_t         rsp_nxt;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^s_araddr[1:0];

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (s_arvalid) state_nxt = RESP;
      RESP: if (s_rready)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_arready = (state == IDLE);
    s_rvalid  = (state == RESP);
  end

  // ---------------- decode / response ----------------
  assign ar_hs     = s_arvalid && s_arready;
  assign word_addr = s_araddr[ADDR_W-1:2];
  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(FIFO_DEPTH));

  always_comb begin
    rsp_nxt      = '0;
    rsp_nxt.resp = RESP_OKAY;
    case (word_addr)
      A_DATA: begin
        rsp_nxt.data = empty ? '0 : mem[rd_ptr];
`ifdef AXI_RD_SLVERR_EN
        if (empty) rsp_nxt.resp = RESP_SLVERR;
`endif
      end
      A_STATUS: begin
        rsp_nxt.data[15:0] = 16'(level);
        rsp_nxt.data[16]   = empty;
        rsp_nxt.data[17]   = full;
        rsp_nxt.data[18]   = ovf;
      end
      A_ID:     rsp_nxt.data = DATA_W'(ID_VALUE);
      A_THRESH: rsp_nxt.data = DATA_W'(IRQ_THRESH);
      default: begin
`ifdef AXI_RD_SLVERR_EN
        rsp_nxt.resp = RESP_SLVERR;
`else
        rsp_nxt.resp = RESP_OKAY;
`endif
      end
    endcase
  end

  // Response is captured at the address handshake and held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rdata <= rsp_nxt.data;
      s_rresp <= rsp_nxt.resp;
    end
  end

  // ---------------- FIFO ----------------
  // A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
  assign pop     = ar_hs && (word_addr == A_DATA) && !empty;
  assign push_ok = i_push && (!full || pop);
  assign ovf_set = i_push && full && !pop;
  assign ovf_clr = ar_hs && (word_addr == A_STATUS);

  assign level_nxt = level + {{(LVL_W-1){1'b0}}, push_ok} - {{(LVL_W-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      o_irq <= (level_nxt >= LVL_W'(IRQ_THRESH));
    end
  end

endmodule

// File: tb/tb_axi_rd_fifo_slave.sv
// Directed bench for axi_rd_fifo_slave: vector table plus hand sequences for multi-cycle corners.
module tb_axi_rd_fifo_slave;

  localparam logic [1:0] ERR =
`ifdef AXI_RD_SLVERR_EN
    2'b10;
`else
    2'b00;
`endif

  logic        clk, rst;
  logic [7:0]  s_araddr;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        i_push;
  logic [31:0] i_push_data;
  logic        o_irq;

  int total_cnt = 0;
  int pass_cnt  = 0;

  axi_rd_fifo_slave dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .i_push(i_push), .i_push_data(i_push_data), .o_irq(o_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_push;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got %h exp %h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    i_push = 1'b1;
    i_push_data = d;
    tick();
    i_push = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    s_araddr = a;
    s_arvalid = 1'b1;
    s_rready = 1'b1;
    while (!s_arready && n < 20) begin
      tick();
      n++;
    end
    chk("arready_before_accept", 32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
    chk("rvalid_after_accept", 32'(s_rvalid), 32'd1);
    chk("arready_during_resp", 32'(s_arready), 32'd0);
    d = s_rdata;
    r = s_rresp;
    tick();
    chk("rvalid_one_cycle", 32'(s_rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    rst = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    i_push = 1'b0; i_push_data = '0;
    tick(); tick();
    chk("rst_arready", 32'(s_arready), 32'd1);
    chk("rst_rvalid",  32'(s_rvalid),  32'd0);
    chk("rst_rdata",   s_rdata,        32'd0);
    chk("rst_rresp",   32'(s_rresp),   32'd0);
    chk("rst_irq",     32'(o_irq),     32'd0);
    rst = 1'b0;

    // {is_push, addr, push_data, exp_rdata, exp_rresp}
    vt.push_back('{1'b0, 8'h08, 32'h0,  32'hC011_0001, 2'b00});
    vt.push_back('{1'b0, 8'h0C, 32'h0,  32'd8,         2'b00});
    vt.push_back('{1'b0, 8'h04, 32'h0,  32'h0001_0000, 2'b00});
    vt.push_back('{1'b1, 8'h00, 32'h11, 32'h0,         2'b00});
    vt.push_back('{1'b1, 8'h00, 32'h22, 32'h0,         2'b00});
    vt.push_back('{1'b1, 8'h00, 32'h33, 32'h0,         2'b00});
    vt.push_back('{1'b0, 8'h04, 32'h0,  32'h0000_0003, 2'b00});
    vt.push_back('{1'b0, 8'h00, 32'h0,  32'h11,        2'b00});
    vt.push_back('{1'b0, 8'h00, 32'h0,  32'h22,        2'b00});
    vt.push_back('{1'b0, 8'h00, 32'h0,  32'h33,        2'b00});
    vt.push_back('{1'b0, 8'h00, 32'h0,  32'h0,         ERR});
    vt.push_back('{1'b0, 8'h04, 32'h0,  32'h0001_0000, 2'b00});
    vt.push_back('{1'b0, 8'h10, 32'h0,  32'h0,         ERR});
    vt.push_back('{1'b0, 8'h0B, 32'h0,  32'hC011_0001, 2'b00});
    vt.push_back('{1'b0, 8'hFC, 32'h0,  32'h0,         ERR});

    foreach (vt[i]) begin
      if (vt[i].is_push) push(vt[i].data);
      else begin
        do_read(vt[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].exp_resp));
      end
    end

    // IRQ threshold, overflow, full push+pop, wrap-around drain
    do_reset();
    for (int i = 0; i < 7; i++) push(32'h100 + 32'(i));
    chk("irq_below_thresh", 32'(o_irq), 32'd0);
    push(32'h107);
    chk("irq_at_thresh", 32'(o_irq), 32'd1);
    do_read(8'h00, d, r);
    chk("pop_first", d, 32'h100);
    chk("irq_after_pop", 32'(o_irq), 32'd0);
    for (int j = 0; j < 10; j++) push(32'h200 + 32'(j));
    chk("irq_full", 32'(o_irq), 32'd1);
    do_read(8'h04, d, r);
    chk("status_ovf", d, 32'h0006_0010);
    do_read(8'h04, d, r);
    chk("status_ovf_cleared", d, 32'h0002_0010);

    i_push = 1'b1; i_push_data = 32'h300;
    s_araddr = 8'h00; s_arvalid = 1'b1; s_rready = 1'b1;
    tick();
    i_push = 1'b0; s_arvalid = 1'b0;
    chk("full_pushpop_data", s_rdata, 32'h101);
    tick();
    do_read(8'h04, d, r);
    chk("full_pushpop_status", d, 32'h0002_0010);

    for (int k = 0; k < 16; k++) begin
      logic [31:0] e;
      e = (k < 6) ? 32'h102 + 32'(k) : (k < 15) ? 32'h200 + 32'(k - 6) : 32'h300;
      do_read(8'h00, d, r);
      chk($sformatf("drain%0d", k), d, e);
    end
    do_read(8'h04, d, r);
    chk("drained_status", d, 32'h0001_0000);
    chk("drained_irq", 32'(o_irq), 32'd0);

    // Push and pop on an empty FIFO: no fall-through
    do_reset();
    i_push = 1'b1; i_push_data = 32'h5A;
    s_araddr = 8'h00; s_arvalid = 1'b1; s_rready = 1'b1;
    tick();
    i_push = 1'b0; s_arvalid = 1'b0;
    chk("empty_pushpop_data", s_rdata, 32'h0);
    chk("empty_pushpop_resp", 32'(s_rresp), 32'(ERR));
    tick();
    do_read(8'h04, d, r);
    chk("empty_pushpop_status", d, 32'h0000_0001);
    do_read(8'h00, d, r);
    chk("empty_pushpop_word", d, 32'h5A);

    // Backpressure: response held, second request waits for the handshake
    push(32'hAA);
    push(32'hBB);
    s_rready = 1'b0; s_araddr = 8'h00; s_arvalid = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rvalid",  32'(s_rvalid),  32'd1);
      chk("bp_rdata",   s_rdata,        32'hAA);
      chk("bp_arready", 32'(s_arready), 32'd0);
      tick();
    end
    s_rready = 1'b1;
    tick();
    chk("bp_rvalid_drop", 32'(s_rvalid),  32'd0);
    chk("bp_arready_up",  32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
    chk("bp_second_rvalid", 32'(s_rvalid), 32'd1);
    chk("bp_second_rdata",  s_rdata,       32'hBB);
    tick();
    do_read(8'h04, d, r);
    chk("bp_status", d, 32'h0001_0000);

    // Reset while a response is pending
    push(32'h77);
    s_rready = 1'b0; s_araddr = 8'h04; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("midrst_rvalid_pre", 32'(s_rvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rvalid",  32'(s_rvalid),  32'd0);
    chk("midrst_arready", 32'(s_arready), 32'd1);
    chk("midrst_rdata",   s_rdata,        32'd0);
    do_read(8'h04, d, r);
    chk("midrst_status", d, 32'h0001_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
